// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_pkg
// Brief   : Shared digit-slot codes, blank pattern and helpers for seg_scan.
// Revision: 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    localparam int         DIGIT_NUM     = 6;
    localparam logic [2:0] SLOT_FARE_A   = 3'd0;
    localparam logic [2:0] SLOT_FARE_B   = 3'd1;
    localparam logic [2:0] SLOT_FARE_C   = 3'd2;
    localparam logic [2:0] SLOT_FARE_D   = 3'd3;
    localparam logic [2:0] SLOT_DIST_A   = 3'd4;
    localparam logic [2:0] SLOT_DIST_B   = 3'd5;
    localparam logic [7:0] SEG_BLANK     = 8'hFF;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blink_phase_e;

    function automatic logic [DIGIT_NUM-1:0] slot_onehot(input logic [2:0] slot);
        return DIGIT_NUM'(1) << slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : scan_prescaler
// Brief   : Free-running 0..SCAN_DIV-1 counter with a terminal-count tick.
// Revision: 1.0 - initial release
// ============================================================================
module scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] cnt,
    output logic        tick
);

    logic [15:0] r_cnt;

    assign tick = (r_cnt == (SCAN_DIV - 16'd1));
    assign cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (tick) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan
// Brief   : Six-digit 7-segment scanner with per-frame snapshot, anti-ghost
//           blanking and fare-digit blinking on overflow.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50_000,
    parameter logic [15:0] BLANK_CYCLES   = 16'd500,
    parameter logic [7:0]  BLINK_FRAMES   = 8'd100,
    parameter logic [7:0]  SEG_OFF        = SEG_BLANK,
    parameter logic        DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 max,
    input  logic [7:0]           fare_a,
    input  logic [7:0]           fare_b,
    input  logic [7:0]           fare_c,
    input  logic [7:0]           fare_d,
    input  logic [7:0]           distance_a,
    input  logic [7:0]           distance_b,
    output logic [7:0]           seg,
    output logic [DIGIT_NUM-1:0] dig_sel,
    output logic                 frame_start
);

    localparam logic [DIGIT_NUM-1:0] c_DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

    logic [15:0]          w_cnt;
    logic                 w_tick;
    logic                 w_frame_wrap;
    logic                 w_blank;
    logic [DIGIT_NUM-1:0] w_sel;

    logic [2:0]           r_slot;
    logic [7:0]           r_shadow [DIGIT_NUM];
    logic [7:0]           r_fcnt;
    blink_phase_e         r_phase;
    logic                 r_seen_low;
    logic                 r_wrapped;
    logic [7:0]           r_seg;
    logic [DIGIT_NUM-1:0] r_dig;
    logic                 r_fs;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (w_cnt),
        .tick  (w_tick)
    );

    assign w_frame_wrap = w_tick && (r_slot == SLOT_DIST_B);

    always_comb begin
        w_blank = (w_cnt < BLANK_CYCLES) || !en ||
                  ((r_slot <= SLOT_FARE_D) && max && (r_phase == PHASE_OFF));
        w_sel   = en ? slot_onehot(r_slot) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot     <= SLOT_FARE_A;
            for (int i = 0; i < DIGIT_NUM; i++) begin
                r_shadow[i] <= SEG_OFF;
            end
            r_fcnt     <= 8'd0;
            r_phase    <= PHASE_ON;
            r_seen_low <= 1'b0;
            r_wrapped  <= 1'b0;
            r_seg      <= SEG_OFF;
            r_dig      <= c_DIG_IDLE;
            r_fs       <= 1'b0;
        end else begin
            if (w_tick) begin
                r_slot <= w_frame_wrap ? SLOT_FARE_A : r_slot + 3'd1;
            end

            if (w_frame_wrap) begin
                r_shadow[SLOT_FARE_A] <= fare_a;
                r_shadow[SLOT_FARE_B] <= fare_b;
                r_shadow[SLOT_FARE_C] <= fare_c;
                r_shadow[SLOT_FARE_D] <= fare_d;
                r_shadow[SLOT_DIST_A] <= distance_a;
                r_shadow[SLOT_DIST_B] <= distance_b;
            end

            // frame_start lands with dig_sel's move to slot 0, one cycle after the slot register wraps
            r_wrapped <= w_frame_wrap;
            r_fs      <= r_wrapped;

            // Only frames spent entirely with max high advance the blink counter
            r_seen_low <= w_frame_wrap ? 1'b0 : (r_seen_low | ~max);

            if (!max) begin
                r_fcnt  <= 8'd0;
                r_phase <= PHASE_ON;
            end else if (w_frame_wrap && !r_seen_low) begin
                if (r_fcnt == (BLINK_FRAMES - 8'd1)) begin
                    r_fcnt  <= 8'd0;
                    r_phase <= (r_phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
                end else begin
                    r_fcnt  <= r_fcnt + 8'd1;
                end
            end

            r_seg <= w_blank ? SEG_OFF : r_shadow[r_slot];
            r_dig <= DIG_ACTIVE_LOW ? ~w_sel : w_sel;
        end
    end

    assign seg         = r_seg;
    assign dig_sel     = r_dig;
    assign frame_start = r_fs;

endmodule
`default_nettype wire
